led_code_sched: RTL



---
 rtl/led_code_pkg.sv | 20 ++
 rtl/led_tick_prescaler.sv | 28 ++
 rtl/led_code_sched.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/led_code_pkg.sv
// Shared types for the status-LED code scheduler: FSM state encoding and
// a lowest-set-bit helper used by the request arbiter.
package led_code_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } state_t;

    // Index of the lowest set bit; 0 when no bit is set. Supports up to 32 requesters.
    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        lowest_set = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) lowest_set = 5'(i);
        end
    endfunction

endpackage

// File: rtl/led_tick_prescaler.sv
// Tick prescaler: counts 0..DIV-1 and emits a single-cycle tick on the
// terminal count. clr holds the count at zero.
module led_tick_prescaler #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count;

    assign tick = (count == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (clr || tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/led_code_sched.sv
// Status-LED scheduler: heartbeat blink when idle, otherwise (idx+1)-pulse
// blink codes for the highest-priority requester. Optional request latching
// is enabled with the LED_CODE_REQ_LATCH_EN macro.
module led_code_sched
    import led_code_pkg::*;
#(
    parameter int DIV       = 50000,
    parameter int NUM_REQ   = 4,
    parameter int ON_TICKS  = 25,
    parameter int GAP_TICKS = 100,
    parameter int HB_TICKS  = 50,
    localparam int AW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    output logic               led,
    output logic               busy,
    output logic [AW-1:0]      active_idx,
    output logic               seq_done
);

    localparam int MAXT0 = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
    localparam int MAXT  = (MAXT0 > HB_TICKS) ? MAXT0 : HB_TICKS;
    localparam int TW    = (MAXT > 1) ? $clog2(MAXT) : 1;
    localparam int PW    = $clog2(NUM_REQ + 1);

    state_t             state;
    logic [TW-1:0]      tick_cnt;
    logic [PW-1:0]      pulses_left;
    logic               hb_state;
    logic               tick;
    logic [NUM_REQ-1:0] arb;
    logic [4:0]         win;
    logic [5:0]         win_p1;
    logic               on_last;
    logic               gap_last;
    logic               hb_last;

    led_tick_prescaler #(.DIV(DIV)) u_presc (
        .clk  (clk),
        .rstn (rstn),
        .clr  (!enable),
        .tick (tick)
    );

    assign on_last  = (tick_cnt == TW'(ON_TICKS - 1));
    assign gap_last = (tick_cnt == TW'(GAP_TICKS - 1));
    assign hb_last  = (tick_cnt == TW'(HB_TICKS - 1));

`ifdef LED_CODE_REQ_LATCH_EN
    logic [NUM_REQ-1:0] req_q;
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] done_clr;
    logic               gap_end;

    assign gap_end = enable && tick && (state == GAP) && gap_last;
    assign arb     = pending | req;

    always_comb begin
        done_clr = '0;
        if (gap_end) done_clr = NUM_REQ'(1) << active_idx;
    end

    // A rising edge in the same cycle as the clear keeps the bit pending.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_q   <= '0;
            pending <= '0;
        end else begin
            req_q <= req;
            if (!enable) pending <= '0;
            else         pending <= (pending & ~done_clr) | (req & ~req_q);
        end
    end
`else
    assign arb = req;
`endif

    always_comb begin
        win    = lowest_set(32'(arb));
        win_p1 = {1'b0, win} + 6'd1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            pulses_left <= '0;
            hb_state    <= 1'b0;
            led         <= 1'b0;
            busy        <= 1'b0;
            active_idx  <= '0;
            seq_done    <= 1'b0;
        end else if (!enable) begin
            state    <= IDLE;
            tick_cnt <= '0;
            hb_state <= 1'b0;
            led      <= 1'b0;
            busy     <= 1'b0;
            seq_done <= 1'b0;
        end else begin
            seq_done <= 1'b0;
            if (tick) begin
                case (state)
                    IDLE: begin
                        if (arb != '0) begin
                            active_idx  <= AW'(win);
                            pulses_left <= win_p1[PW-1:0];
                            busy        <= 1'b1;
                            led         <= 1'b1;
                            tick_cnt    <= '0;
                            state       <= ON;
                        end else if (hb_last) begin
                            hb_state <= ~hb_state;
                            led      <= ~hb_state;
                            tick_cnt <= '0;
                        end else begin
                            led      <= hb_state;
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    ON: begin
                        if (on_last) begin
                            pulses_left <= pulses_left - PW'(1);
                            led         <= 1'b0;
                            tick_cnt    <= '0;
                            state       <= OFF;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    OFF: begin
                        if (on_last) begin
                            tick_cnt <= '0;
                            if (pulses_left == '0) begin
                                state <= GAP;
                            end else begin
                                led   <= 1'b1;
                                state <= ON;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    GAP: begin
                        if (gap_last) begin
                            seq_done <= 1'b1;
                            busy     <= 1'b0;
                            hb_state <= 1'b0;
                            led      <= 1'b0;
                            tick_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
